// File: rtl/reg_fault_array_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : reg_fault_array_if                                            |
// | Description : Control/status bundle between the fault-injection bench and   |
// |               the laser-target register array.                              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
interface reg_fault_array_if #(
  parameter int N_REGS = 8,
  parameter int CNT_W  = 32
);
  localparam int IDX_W = $clog2(N_REGS);

  logic [N_REGS-1:0] en;
  logic [1:0]        mode;
  logic [N_REGS-1:0] seed;
  logic              load;
  logic              clear_flags;
  logic [N_REGS-1:0] regs;
  logic [N_REGS-1:0] fault;
  logic              fault_any;
  logic [CNT_W-1:0]  fault_cycle;
  logic [IDX_W-1:0]  fault_idx;
  logic [CNT_W-1:0]  cycle_cnt;

  // Bench / board side: drives controls, observes status
  modport master (
    output en, mode, seed, load, clear_flags,
    input  regs, fault, fault_any, fault_cycle, fault_idx, cycle_cnt
  );

  // Register-array side
  modport slave (
    input  en, mode, seed, load, clear_flags,
    output regs, fault, fault_any, fault_cycle, fault_idx, cycle_cnt
  );
endinterface
`default_nettype wire

// File: rtl/reg_fault_array.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : reg_fault_array                                               |
// | Description : Target register array with a golden shadow copy, per-cycle    |
// |               mismatch detector, sticky fault flags and first-fault capture.|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module reg_fault_array #(
  parameter int N_REGS = 8,
  parameter int CNT_W  = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  reg_fault_array_if.slave   bus
);
  localparam int IDX_W = $clog2(N_REGS);

  localparam logic [1:0] C_MODE_CLEAR  = 2'b00;
  localparam logic [1:0] C_MODE_TOGGLE = 2'b01;
  localparam logic [1:0] C_MODE_HOLD   = 2'b10;

  // Targets and shadow must stay physically distinct so an upset in one copy
  // is observable against the other.
  (* dont_touch = "true", keep = "true" *) logic [N_REGS-1:0] r_regs;
  (* dont_touch = "true", keep = "true" *) logic [N_REGS-1:0] r_shadow;

  logic [N_REGS-1:0] r_fault;
  logic              r_fault_any;
  logic [CNT_W-1:0]  r_fault_cycle;
  logic [IDX_W-1:0]  r_fault_idx;
  logic [CNT_W-1:0]  r_cycle_cnt;

  logic [N_REGS-1:0] w_regs_nxt;
  logic [N_REGS-1:0] w_shadow_nxt;
  logic [N_REGS-1:0] w_mism;
  logic [IDX_W-1:0]  w_low_idx;
  logic              w_capture;
  logic [N_REGS-1:0] w_fault_nxt;
  logic              w_fault_any_nxt;
  logic [CNT_W-1:0]  w_fault_cycle_nxt;
  logic [IDX_W-1:0]  w_fault_idx_nxt;
  logic [CNT_W-1:0]  w_cycle_cnt_nxt;

  // Shared next-state rule; each copy feeds back only its own value.
  function automatic logic [N_REGS-1:0] f_next(
    input logic [N_REGS-1:0] x,
    input logic              ld,
    input logic [1:0]        md,
    input logic [N_REGS-1:0] sd,
    input logic [N_REGS-1:0] e
  );
    logic [N_REGS-1:0] y;
    if (ld) begin
      y = sd;
    end else begin
      case (md)
        C_MODE_CLEAR:  y = '0;
        C_MODE_TOGGLE: y = e & ~x;
        C_MODE_HOLD:   y = x;
        default:       y = {x[N_REGS-2:0], x[N_REGS-1]};
      endcase
    end
    return y;
  endfunction

  // Next values for both register copies
  always_comb begin
    w_regs_nxt   = f_next(r_regs,   bus.load, bus.mode, bus.seed, bus.en);
    w_shadow_nxt = f_next(r_shadow, bus.load, bus.mode, bus.seed, bus.en);
  end

  assign w_mism = r_regs ^ r_shadow;

  // Lowest mismatching bit index (scan from the top so the lowest wins)
  always_comb begin
    w_low_idx = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (w_mism[i]) w_low_idx = IDX_W'(i);
    end
  end

  // Flag, capture and counter update; a live mismatch overrides clear_flags
  always_comb begin
    w_capture         = (|w_mism) && (bus.clear_flags || !r_fault_any);
    w_fault_nxt       = bus.clear_flags ? w_mism : (r_fault | w_mism);
    w_fault_any_nxt   = |w_fault_nxt;
    w_fault_cycle_nxt = r_fault_cycle;
    w_fault_idx_nxt   = r_fault_idx;
    if (w_capture) begin
      w_fault_cycle_nxt = r_cycle_cnt;
      w_fault_idx_nxt   = w_low_idx;
    end else if (bus.clear_flags) begin
      w_fault_cycle_nxt = '0;
      w_fault_idx_nxt   = '0;
    end
    if (bus.clear_flags) begin
      w_cycle_cnt_nxt = '0;
    end else if (r_cycle_cnt == {CNT_W{1'b1}}) begin
      w_cycle_cnt_nxt = r_cycle_cnt;
    end else begin
      w_cycle_cnt_nxt = r_cycle_cnt + 1'b1;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs        <= '0;
      r_shadow      <= '0;
      r_fault       <= '0;
      r_fault_any   <= 1'b0;
      r_fault_cycle <= '0;
      r_fault_idx   <= '0;
      r_cycle_cnt   <= '0;
    end else begin
      r_regs        <= w_regs_nxt;
      r_shadow      <= w_shadow_nxt;
      r_fault       <= w_fault_nxt;
      r_fault_any   <= w_fault_any_nxt;
      r_fault_cycle <= w_fault_cycle_nxt;
      r_fault_idx   <= w_fault_idx_nxt;
      r_cycle_cnt   <= w_cycle_cnt_nxt;
    end
  end

  assign bus.regs        = r_regs;
  assign bus.fault       = r_fault;
  assign bus.fault_any   = r_fault_any;
  assign bus.fault_cycle = r_fault_cycle;
  assign bus.fault_idx   = r_fault_idx;
  assign bus.cycle_cnt   = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_fault_array.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_reg_fault_array                                            |
// | Description : Self-checking bench for reg_fault_array: directed scenarios   |
// |               plus randomized traffic against a behavioural model.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_reg_fault_array;
  logic clk;
  logic rst;

  reg_fault_array_if #(.N_REGS(8), .CNT_W(32)) bus ();
  reg_fault_array_if #(.N_REGS(2), .CNT_W(4))  bus2 ();

  reg_fault_array #(.N_REGS(8), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter instance used to reach saturation quickly
  reg_fault_array #(.N_REGS(2), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [7:0]  m_regs, m_shadow, m_fault;
  logic        m_any;
  logic [31:0] m_fcyc, m_cnt;
  logic [2:0]  m_fidx;
  logic [7:0]  frc_val;
  logic [31:0] saved_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Register rule from the mode table, applied to any 8-bit value
  function automatic logic [7:0] rule(input logic [7:0] x);
    int v;
    if (bus.load) return bus.seed;
    case (bus.mode)
      2'd0:    return 8'h00;
      2'd1:    return bus.en & ~x;
      2'd2:    return x;
      default: begin
        v = int'(x);
        v = ((v * 2) + (v / 128)) % 256;
        return v[7:0];
      end
    endcase
  endfunction

  task automatic model_reset();
    m_regs = '0; m_shadow = '0; m_fault = '0; m_any = 1'b0;
    m_fcyc = '0; m_cnt = '0; m_fidx = '0;
  endtask

  // Effect of one clock edge given current inputs
  task automatic model_edge();
    logic [7:0] mism;
    mism = m_regs ^ m_shadow;
    if (bus.clear_flags) begin
      m_fault = mism;
      m_any   = (mism != 0);
      m_fcyc  = (mism != 0) ? m_cnt : 32'd0;
      m_fidx  = (mism != 0) ? 3'(lowest(mism)) : 3'd0;
      m_cnt   = 32'd0;
    end else begin
      if (mism != 0 && !m_any) begin
        m_fcyc = m_cnt;
        m_fidx = 3'(lowest(mism));
      end
      m_fault = m_fault | mism;
      m_any   = (m_fault != 0);
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    m_regs   = rule(m_regs);
    m_shadow = rule(m_shadow);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".regs"},        64'(bus.regs),        64'(m_regs));
    chk({tag, ".fault"},       64'(bus.fault),       64'(m_fault));
    chk({tag, ".fault_any"},   64'(bus.fault_any),   64'(m_any));
    chk({tag, ".fault_cycle"}, 64'(bus.fault_cycle), 64'(m_fcyc));
    chk({tag, ".fault_idx"},   64'(bus.fault_idx),   64'(m_fidx));
    chk({tag, ".cycle_cnt"},   64'(bus.cycle_cnt),   64'(m_cnt));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Flip one bit of targets or shadow across one edge; caller holds mode=10, load=0
  task automatic inject(input bit on_shadow, input int bit_i, input string tag);
    logic [7:0] mask;
    mask = 8'h01 << bit_i;
    if (on_shadow) begin
      m_shadow = m_shadow ^ mask;
      frc_val  = m_shadow;
      force dut.r_shadow = frc_val;
      tick(tag);
      release dut.r_shadow;
    end else begin
      m_regs  = m_regs ^ mask;
      frc_val = m_regs;
      force dut.r_regs = frc_val;
      tick(tag);
      release dut.r_regs;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = '0; bus.mode = 2'b00; bus.seed = '0; bus.load = 1'b0; bus.clear_flags = 1'b0;
    bus2.en = '0; bus2.mode = 2'b00; bus2.seed = '0; bus2.load = 1'b0; bus2.clear_flags = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Toggle with partial enable
    bus.mode = 2'b01; bus.en = 8'h0F;
    for (int k = 1; k <= 20; k++) begin
      tick("toggle");
      chk("toggle.pattern", 64'(bus.regs), (k % 2 == 1) ? 64'h0F : 64'h00);
    end

    // Load then hold
    bus.load = 1'b1; bus.seed = 8'hA5; bus.mode = 2'b10;
    tick("hold.load");
    bus.load = 1'b0;
    repeat (100) tick("hold");
    chk("hold.value", 64'(bus.regs), 64'hA5);

    // Rotate three full wraps
    bus.load = 1'b1; bus.seed = 8'h01; bus.mode = 2'b11;
    tick("rot.load");
    bus.load = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick("rot");
      chk("rot.walk", 64'(bus.regs), 64'(8'h01 << (k % 8)));
    end
    chk("rot.nofault", 64'(bus.fault_any), 64'h0);

    // First-fault capture at cycle 50
    bus.load = 1'b1; bus.seed = 8'h00; bus.mode = 2'b10; bus.clear_flags = 1'b1;
    tick("ff.clear");
    bus.load = 1'b0; bus.clear_flags = 1'b0;
    repeat (50) tick("ff.run");
    inject(1'b0, 3, "ff.flip3");
    chk("ff.fault",  64'(bus.fault),       64'h08);
    chk("ff.cycle",  64'(bus.fault_cycle), 64'd50);
    chk("ff.idx",    64'(bus.fault_idx),   64'd3);
    repeat (100) tick("ff.sticky");
    chk("ff.sticky_fault", 64'(bus.fault), 64'h08);

    // Second fault does not move the capture; clear collides with a new flip
    bus.load = 1'b1;
    tick("two.reload");
    bus.load = 1'b0; bus.clear_flags = 1'b1;
    tick("two.clear");
    bus.clear_flags = 1'b0;
    repeat (5) tick("two.run");
    inject(1'b0, 5, "two.flip5");
    saved_cyc = bus.fault_cycle;
    repeat (7) tick("two.gap");
    inject(1'b0, 1, "two.flip1");
    chk("two.fault", 64'(bus.fault),       64'h22);
    chk("two.idx",   64'(bus.fault_idx),   64'd5);
    chk("two.cycle", 64'(bus.fault_cycle), 64'(saved_cyc));
    bus.load = 1'b1;
    tick("two.reload2");
    bus.load = 1'b0; bus.clear_flags = 1'b1;
    inject(1'b0, 2, "two.clrflip2");
    bus.clear_flags = 1'b0;
    chk("two.clr_fault", 64'(bus.fault),     64'h04);
    chk("two.clr_idx",   64'(bus.fault_idx), 64'd2);
    chk("two.clr_cnt",   64'(bus.cycle_cnt), 64'd0);
    inject(1'b1, 6, "shadow.flip6");
    chk("shadow.fault", 64'(bus.fault), 64'h44);

    // Asynchronous reset in the middle of a toggle run
    bus.load = 1'b1; bus.seed = 8'h00; bus.mode = 2'b01; bus.en = 8'hFF;
    tick("ar.load");
    bus.load = 1'b0;
    repeat (3) tick("ar.toggle");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar.regs",  64'(bus.regs),      64'h0);
    chk("ar.fault", 64'(bus.fault),     64'h0);
    chk("ar.cnt",   64'(bus.cycle_cnt), 64'h0);
    @(posedge clk);
    #1;
    check_all("ar.held");
    rst = 1'b0;

    // Counter saturation on the narrow instance
    for (int k = 1; k <= 20; k++) begin
      tick("ar.post");
      chk("sat.cnt", 64'(bus2.cycle_cnt), (k > 15) ? 64'd15 : 64'(k));
    end

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus.mode        = 2'($urandom_range(0, 3));
      bus.en          = 8'($urandom);
      bus.seed        = 8'($urandom);
      bus.load        = ($urandom_range(0, 7) == 0);
      bus.clear_flags = ($urandom_range(0, 15) == 0);
      if (bus.mode == 2'b10 && !bus.load && $urandom_range(0, 5) == 0)
        inject(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), "rnd.inj");
      else
        tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
